// File: rtl/alu_pkg.sv
// Shared ALU opcode, flag-index and opcode-count definitions
// for the pipelined ALU and its combinational core.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_MIN = 4'd8,
    OP_MAX = 4'd9,
    OP_CMP = 4'd10
  } alu_op_e;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  localparam int ALU_OP_COUNT = 11;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: result, {C,V,Z,N} flags and
// illegal-opcode error.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             err
);

  localparam logic [WIDTH-1:0] W_V = WIDTH'(WIDTH);

  logic [WIDTH-1:0]        sh;
  logic [WIDTH-1:0]        prod;
  logic [WIDTH:0]          sum;
  logic [WIDTH:0]          dif;
  logic [WIDTH:0]          shl_x;
  logic [WIDTH:0]          lsr_x;
  logic signed [WIDTH:0]   asr_x;
  logic [WIDTH:0]          shr_x;
  logic                    lt;
  logic                    c;
  logic                    v;
  logic                    msb_a;
  logic                    msb_b;

  always_comb begin
    sh    = b % W_V;
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    // Extra guard bit catches the last bit shifted out.
    shl_x = {1'b0, a} << sh;
    lsr_x = {a, 1'b0} >> sh;
    asr_x = $signed({a, 1'b0}) >>> sh;
    shr_x = sgn ? asr_x : lsr_x;
    prod  = a * b;
    msb_a = a[WIDTH-1];
    msb_b = b[WIDTH-1];
    if (sgn) lt = $signed(a) < $signed(b);
    else     lt = a < b;

    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = sgn & (msb_a == msb_b)
                  & (sum[WIDTH-1] != msb_a);
      end
      OP_SUB: begin
        res = dif[WIDTH-1:0];
        c   = dif[WIDTH];
        v   = sgn & (msb_a != msb_b)
                  & (dif[WIDTH-1] != msb_a);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        res = shl_x[WIDTH-1:0];
        c   = shl_x[WIDTH];
      end
      OP_SHR: begin
        res = shr_x[WIDTH:1];
        c   = shr_x[0];
      end
      OP_MUL: res = prod;
      OP_MIN: res = lt ? a : b;
      OP_MAX: res = lt ? b : a;
      OP_CMP: res = {{(WIDTH-1){1'b0}}, lt};
      default: err = 1'b1;
    endcase

    flags         = '0;
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
    flags[FLAG_Z] = ~|res;
    flags[FLAG_N] = res[WIDTH-1];
    if (err) flags = '0;
  end

endmodule

// File: rtl/param_alu_pipe.sv
// Two-stage valid/ready ALU pipeline: optional operand register,
// then alu_core, then a result register feeding the output.
module param_alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int REG_IN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  logic             s1_adv;
  logic             v1;
  logic [3:0]       op1;
  logic             sgn1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;

  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flags;
  logic             core_err;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic [3:0]       s2_flags_q, s2_flags_d;
  logic             s2_err_q, s2_err_d;

  assign s1_adv = !s2_valid_q || out_ready;

  if (REG_IN != 0) begin : g_reg
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic             s1_sgn_q, s1_sgn_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;

    assign in_ready = !s1_valid_q || s1_adv;

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_sgn_d   = s1_sgn_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (in_ready) s1_valid_d = in_valid;
      if (in_valid && in_ready) begin
        s1_op_d  = in_op;
        s1_sgn_d = in_signed;
        s1_a_d   = in_a;
        s1_b_d   = in_b;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_op_q    <= '0;
        s1_sgn_q   <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_op_q    <= s1_op_d;
        s1_sgn_q   <= s1_sgn_d;
        s1_a_q     <= s1_a_d;
        s1_b_q     <= s1_b_d;
      end
    end

    assign v1   = s1_valid_q;
    assign op1  = s1_op_q;
    assign sgn1 = s1_sgn_q;
    assign a1   = s1_a_q;
    assign b1   = s1_b_q;
  end else begin : g_byp
    // Without the operand register the request feeds the core directly.
    assign in_ready = s1_adv;
    assign v1       = in_valid;
    assign op1      = in_op;
    assign sgn1     = in_signed;
    assign a1       = in_a;
    assign b1       = in_b;
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (op1),
    .sgn   (sgn1),
    .a     (a1),
    .b     (b1),
    .res   (core_res),
    .flags (core_flags),
    .err   (core_err)
  );

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    s2_err_d   = s2_err_q;
    if (s1_adv) s2_valid_d = v1;
    if (v1 && s1_adv) begin
      s2_res_d   = core_res;
      s2_flags_d = core_flags;
      s2_err_d   = core_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_res_q;
  assign out_flags  = s2_flags_q;
  assign out_err    = s2_err_q;

endmodule

// File: tb/tb_param_alu_pipe.sv
// Directed and random checks of param_alu_pipe (WIDTH=8,
// REG_IN=1) against an arithmetic reference model.
module tb_param_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic         in_signed;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic         out_err;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   acc_cyc[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_stall = -1;
  bit   prev_stall = 1'b0;
  bit   last_acc = 1'b0;

  param_alu_pipe #(.WIDTH(W), .REG_IN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_signed  (in_signed),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int sx(int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic exp_t model(int op, bit sgn, int a, int b);
    exp_t e;
    int sa = sx(a);
    int sb = sx(b);
    int sh = b % W;
    int r = 0;
    int s;
    bit c = 0, v = 0, er = 0, lt;
    lt = sgn ? (sa < sb) : (a < b);
    case (op)
      0: begin
        r = a + b; c = (r > 255);
        s = sa + sb; v = sgn && (s > 127 || s < -128);
      end
      1: begin
        r = a - b; c = (a < b);
        s = sa - sb; v = sgn && (s > 127 || s < -128);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        r = a << sh;
        c = (sh != 0) && (((a >> (W - sh)) & 1) != 0);
      end
      6: begin
        r = sgn ? (sa >>> sh) : (a >> sh);
        c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0);
      end
      7: r = a * b;
      8: r = lt ? a : b;
      9: r = lt ? b : a;
      10: r = lt ? 1 : 0;
      default: er = 1;
    endcase
    r = r & 255;
    e.res = 8'(r);
    e.err = er;
    if (er) e.flags = 4'b0;
    else e.flags = {c, v, (r == 0), (((r >> 7) & 1) != 0)};
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   lat;
    @(negedge clk);
    cyc++;
    last_acc = 1'b0;
    if (!rst) begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      if (prev_stall) chk("held_valid", out_valid, 1);
      if (q.size() == 0) begin
        chk("no_stale", out_valid, 0);
      end else if (out_valid) begin
        e = q[0];
        chk("result", out_result, e.res);
        chk("flags", out_flags, e.flags);
        chk("err", out_err, e.err);
        if (out_ready) begin
          void'(q.pop_front());
          lat = acc_cyc.pop_front();
          if (lat > last_stall) chk("latency", cyc - lat, 2);
        end
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) last_stall = cyc;
      if (in_valid && in_ready) begin
        q.push_back(model(int'(in_op), in_signed,
                          int'(in_a), int'(in_b)));
        acc_cyc.push_back(cyc);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int op, bit sgn, int a, int b);
    in_valid  = 1'b1;
    in_op     = 4'(op);
    in_signed = sgn;
    in_a      = 8'(a);
    in_b      = 8'(b);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("send_accept", last_acc, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_op = '0;
    in_signed = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_err", out_err, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    send(0, 0, 8'hFF, 8'h01);
    drain();
    send(0, 1, 8'h7F, 8'h01);
    drain();

    send(1, 0, 5, 3);
    send(7, 0, 8'h10, 8'h10);
    send(6, 1, 8'h80, 1);
    drain();

    send(5, 0, 8'h81, 0);
    send(5, 0, 8'h81, 8);
    send(5, 0, 8'h81, 9);
    send(6, 0, 8'h81, 7);
    send(1, 1, 8'h80, 1);
    send(1, 0, 3, 5);
    send(10, 1, 8'hFF, 1);
    send(10, 0, 8'hFF, 1);
    send(8, 1, 8'h80, 8'h7F);
    send(9, 0, 8'h80, 8'h7F);
    drain();

    out_ready = 1'b0;
    send(2, 0, 8'hF0, 8'h3C);
    send(3, 0, 8'hF0, 8'h0F);
    in_valid = 1'b1;
    in_op = 4'd4;
    in_a = 8'hAA;
    in_b = 8'hAA;
    chk("full_ready", in_ready, 0);
    repeat (4) tick();
    out_ready = 1'b1;
    send(4, 0, 8'hAA, 8'hAA);
    drain();

    send(13, 0, 8'h55, 8'hAA);
    drain();

    send(0, 0, 1, 2);
    send(2, 0, 8'hF0, 8'h3C);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_flags", out_flags, 0);
    chk("mid_rst_err", out_err, 0);
    chk("mid_rst_ready", in_ready, 1);
    q.delete();
    acc_cyc.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) tick();
    send(4, 0, 8'hA5, 8'h5A);
    drain();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      in_signed = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
